dma_prog_regs: RTL and testbench

Parametrised program-mode register file for the DMA controller. It decodes CPU I/O accesses and holds the programmable state:
- per-channel base address, base word count and mode
- command, mask, software-request and terminal-count status
- a multi-byte byte pointer and a mode-read counter

It adds what the flat per-command strobe decode lacks: edge-qualified accesses, registered state, configurable channel count and counter width, and single-bit mask/request commands. It sits between the CPU bus pins and the per-channel transfer datapath.

---
 rtl/dma_prog_regs.sv | 219 +++++++++++++++++++++
 tb/tb_dma_prog_regs.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_prog_regs.sv
// DMA program-mode register file: decodes edge-qualified CPU I/O accesses into base/mode/control state.
// Optional DMA_PROG_SINGLE_BIT_CMD_EN enables the single-bit request (+1) and mask (+2) commands.
module dma_prog_regs #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int A_W    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cs_n,
  input  logic                    hlda,
  input  logic                    ior_n,
  input  logic                    iow_n,
  input  logic [A_W-1:0]          addr_l,
  input  logic [7:0]              db_in,
  output logic [7:0]              db_out,
  output logic                    db_oe,
  input  logic [NUM_CH*CNT_W-1:0] curr_addr,
  input  logic [NUM_CH*CNT_W-1:0] curr_wc,
  input  logic [NUM_CH-1:0]       tc,
  input  logic [NUM_CH-1:0]       dreq_st,
  output logic [NUM_CH*CNT_W-1:0] base_addr,
  output logic [NUM_CH*CNT_W-1:0] base_wc,
  output logic [NUM_CH-1:0]       load_addr,
  output logic [NUM_CH-1:0]       load_wc,
  output logic [NUM_CH*6-1:0]     mode,
  output logic [7:0]              cmd,
  output logic [NUM_CH-1:0]       mask,
  output logic [NUM_CH-1:0]       sw_req,
  output logic                    mclr
);

  localparam int NB = CNT_W / 8;

  logic              ior_prev_reg, iow_prev_reg;
  logic              rd_ev, wr_ev, acc_ok;
  logic              chan_hit, ctrl_hit, wc_sel, ctrl_rd, ctrl_wr, mclr_ev, last_byte;
  logic [2:0]        ctrl_off;
  logic [1:0]        ch_idx, cmd_sel;
  logic [NUM_CH-1:0] chan_dec, ch_dec;
  logic [1:0]        bp_reg, mrc_reg;
  logic [7:0]        cmd_reg, db_out_reg, rd_data;
  logic [NUM_CH-1:0] mask_reg, tc_flag_reg, load_addr_reg, load_wc_reg;
  logic              db_oe_reg, mclr_reg;
  logic [5:0]        mode_sel;

  // Previous strobe levels reset low so a strobe held through reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ior_prev_reg <= 1'b0;
      iow_prev_reg <= 1'b0;
    end else begin
      ior_prev_reg <= ior_n;
      iow_prev_reg <= iow_n;
    end
  end

  assign acc_ok    = !cs_n && !hlda && (ior_n != iow_n);
  assign rd_ev     = acc_ok && !ior_n && ior_prev_reg;
  assign wr_ev     = acc_ok && !iow_n && iow_prev_reg;
  assign chan_hit  = addr_l < A_W'(2 * NUM_CH);
  assign ctrl_hit  = addr_l[3];
  assign ctrl_off  = addr_l[2:0];
  assign ch_idx    = addr_l[2:1];
  assign wc_sel    = addr_l[0];
  assign cmd_sel   = db_in[1:0];
  assign ctrl_rd   = rd_ev && ctrl_hit;
  assign ctrl_wr   = wr_ev && ctrl_hit;
  assign mclr_ev   = ctrl_wr && (ctrl_off == 3'd5);
  assign last_byte = bp_reg == 2'(NB - 1);

  // Selects of NUM_CH or above match no bit and so fall through as no-ops.
  always_comb begin
    chan_dec = '0;
    ch_dec   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      chan_dec[i] = chan_hit && (ch_idx == 2'(i));
      ch_dec[i]   = cmd_sel == 2'(i);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] base_addr_reg, base_wc_reg;
      logic [5:0]       mode_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          base_addr_reg <= '0;
          base_wc_reg   <= '0;
          mode_reg      <= '0;
        end else begin
          if (wr_ev && chan_dec[gi] && !wc_sel)
            base_addr_reg[8*bp_reg +: 8] <= db_in;
          if (wr_ev && chan_dec[gi] && wc_sel)
            base_wc_reg[8*bp_reg +: 8] <= db_in;
          if (ctrl_wr && (ctrl_off == 3'd3) && ch_dec[gi])
            mode_reg <= db_in[7:2];
        end
      end

      assign base_addr[gi*CNT_W +: CNT_W] = base_addr_reg;
      assign base_wc[gi*CNT_W +: CNT_W]   = base_wc_reg;
      assign mode[gi*6 +: 6]              = mode_reg;
    end
  endgenerate

`ifdef DMA_PROG_SINGLE_BIT_CMD_EN
  localparam bit SINGLE_BIT_EN = 1'b1;
  logic [NUM_CH-1:0] sw_req_reg, sw_req_next;

  // A terminal count cancels any pending software request on that channel.
  always_comb begin
    sw_req_next = sw_req_reg;
    if (ctrl_wr && (ctrl_off == 3'd1))
      sw_req_next = (sw_req_reg & ~ch_dec) | (ch_dec & {NUM_CH{db_in[2]}});
    sw_req_next = sw_req_next & ~tc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        sw_req_reg <= '0;
    else if (mclr_ev) sw_req_reg <= '0;
    else              sw_req_reg <= sw_req_next;
  end

  assign sw_req = sw_req_reg;
`else
  localparam bit SINGLE_BIT_EN = 1'b0;
  assign sw_req = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bp_reg      <= '0;
      mrc_reg     <= '0;
      cmd_reg     <= '0;
      mask_reg    <= '1;
      tc_flag_reg <= '0;
    end else if (mclr_ev) begin
      bp_reg      <= '0;
      mrc_reg     <= '0;
      cmd_reg     <= '0;
      mask_reg    <= '1;
      tc_flag_reg <= '0;
    end else begin
      if (ctrl_hit && (ctrl_off == 3'd4) && (rd_ev || wr_ev))
        bp_reg <= '0;
      else if ((rd_ev || wr_ev) && chan_hit)
        bp_reg <= last_byte ? 2'd0 : bp_reg + 2'd1;

      if (ctrl_rd && (ctrl_off == 3'd6))
        mrc_reg <= '0;
      else if (ctrl_rd && (ctrl_off == 3'd3))
        mrc_reg <= (mrc_reg == 2'(NUM_CH - 1)) ? 2'd0 : mrc_reg + 2'd1;

      if (ctrl_wr && (ctrl_off == 3'd0))
        cmd_reg <= db_in;

      if (ctrl_wr && (ctrl_off == 3'd6))
        mask_reg <= '0;
      else if (ctrl_wr && (ctrl_off == 3'd7))
        mask_reg <= db_in[NUM_CH-1:0];
      else if (SINGLE_BIT_EN && ctrl_wr && (ctrl_off == 3'd2))
        mask_reg <= (mask_reg & ~ch_dec) | (ch_dec & {NUM_CH{db_in[2]}});

      // New terminal counts win over a same-cycle status-read clear.
      tc_flag_reg <= ((ctrl_rd && (ctrl_off == 3'd0)) ? '0 : tc_flag_reg) | tc;
    end
  end

  always_comb begin
    mode_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (mrc_reg == 2'(i)) mode_sel = mode[i*6 +: 6];
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (chan_dec[i])
        rd_data = wc_sel ? curr_wc[i*CNT_W + 8*32'(bp_reg) +: 8]
                         : curr_addr[i*CNT_W + 8*32'(bp_reg) +: 8];
    if (ctrl_hit) begin
      case (ctrl_off)
        3'd0:    rd_data = {4'(dreq_st), 4'(tc_flag_reg)};
        3'd3:    rd_data = {mode_sel, mrc_reg};
        3'd7:    rd_data = 8'(mask_reg);
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_out_reg    <= '0;
      db_oe_reg     <= 1'b0;
      load_addr_reg <= '0;
      load_wc_reg   <= '0;
      mclr_reg      <= 1'b0;
    end else begin
      if (rd_ev) db_out_reg <= rd_data;
      if (rd_ev)              db_oe_reg <= 1'b1;
      else if (ior_n || cs_n) db_oe_reg <= 1'b0;
      load_addr_reg <= (wr_ev && !wc_sel && last_byte) ? chan_dec : '0;
      load_wc_reg   <= (wr_ev && wc_sel && last_byte) ? chan_dec : '0;
      mclr_reg      <= mclr_ev;
    end
  end

  assign db_out    = db_out_reg;
  assign db_oe     = db_oe_reg;
  assign load_addr = load_addr_reg;
  assign load_wc   = load_wc_reg;
  assign cmd       = cmd_reg;
  assign mask      = mask_reg;
  assign mclr      = mclr_reg;

endmodule

// File: tb/tb_dma_prog_regs.sv
// Self-checking bench for dma_prog_regs (NUM_CH=4, CNT_W=24): directed table, hand sequences, random ops vs model.
module tb_dma_prog_regs;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 24;
  localparam int NB     = 3;
`ifdef DMA_PROG_SINGLE_BIT_CMD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cs_n = 1'b1, hlda = 1'b0, ior_n = 1'b1, iow_n = 1'b1;
  logic [3:0] addr_l = '0;
  logic [7:0] db_in = '0;
  logic [7:0] db_out;
  logic db_oe, mclr;
  logic [NUM_CH*CNT_W-1:0] curr_addr = '0, curr_wc = '0, base_addr, base_wc;
  logic [NUM_CH-1:0] tc = '0, dreq_st = '0, load_addr, load_wc, mask, sw_req;
  logic [NUM_CH*6-1:0] mode;
  logic [7:0] cmd;

  dma_prog_regs #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .A_W(4)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .hlda(hlda), .ior_n(ior_n), .iow_n(iow_n),
    .addr_l(addr_l), .db_in(db_in), .db_out(db_out), .db_oe(db_oe),
    .curr_addr(curr_addr), .curr_wc(curr_wc), .tc(tc), .dreq_st(dreq_st),
    .base_addr(base_addr), .base_wc(base_wc), .load_addr(load_addr), .load_wc(load_wc),
    .mode(mode), .cmd(cmd), .mask(mask), .sw_req(sw_req), .mclr(mclr)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0, load1_cnt = 0;
  always @(posedge clk) if (load_addr[1]) load1_cnt <= load1_cnt + 1;

  // Behavioural model state
  int unsigned m_base_addr[NUM_CH], m_base_wc[NUM_CH], m_mode[NUM_CH];
  int unsigned m_curr_addr[NUM_CH], m_curr_wc[NUM_CH];
  int unsigned m_cmd, m_mask, m_sw, m_tcf, m_bp, m_mrc, m_dreq, exp_db;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_base_addr[c] = 0; m_base_wc[c] = 0; m_mode[c] = 0;
    end
    m_cmd = 0; m_mask = 15; m_sw = 0; m_tcf = 0; m_bp = 0; m_mrc = 0; exp_db = 0;
  endtask

  task automatic master_clear();
    m_cmd = 0; m_tcf = 0; m_sw = 0; m_bp = 0; m_mrc = 0; m_mask = 15;
  endtask

  task automatic apply_tc(input int unsigned v);
    m_tcf = m_tcf | v;
    m_sw  = m_sw & ~v;
  endtask

  task automatic model_event(input bit wr, input int unsigned a, input int unsigned d,
                             output int unsigned rd_val, output int unsigned ld_a,
                             output int unsigned ld_w, output bit mc);
    int unsigned c, shift, sel, bit_v;
    rd_val = 0; ld_a = 0; ld_w = 0; mc = 0;
    shift = 8 * m_bp;
    if (a < 2 * NUM_CH) begin
      c = a / 2;
      if (wr) begin
        if (a % 2 == 1) m_base_wc[c]   = (m_base_wc[c]   & ~(32'hFF << shift)) | (d << shift);
        else            m_base_addr[c] = (m_base_addr[c] & ~(32'hFF << shift)) | (d << shift);
        if (m_bp == NB - 1) begin
          if (a % 2 == 1) ld_w = 1 << c; else ld_a = 1 << c;
        end
      end else begin
        rd_val = (((a % 2 == 1) ? m_curr_wc[c] : m_curr_addr[c]) >> shift) & 8'hFF;
      end
      m_bp = (m_bp + 1) % NB;
    end else if (a >= 8) begin
      sel = d % 4;
      bit_v = (d >> 2) & 1;
      if (wr) begin
        case (a - 8)
          0: m_cmd = d;
          1: if (SB) m_sw = (m_sw & ~(1 << sel)) | (bit_v << sel);
          2: if (SB) m_mask = (m_mask & ~(1 << sel)) | (bit_v << sel);
          3: m_mode[sel] = d >> 2;
          4: m_bp = 0;
          5: begin master_clear(); mc = 1; end
          6: m_mask = 0;
          default: m_mask = d & 15;
        endcase
      end else begin
        case (a - 8)
          0: begin rd_val = (m_dreq << 4) | m_tcf; m_tcf = 0; end
          3: begin rd_val = (m_mode[m_mrc] << 2) | m_mrc; m_mrc = (m_mrc + 1) % NUM_CH; end
          4: m_bp = 0;
          6: m_mrc = 0;
          7: rd_val = m_mask;
          default: rd_val = 0;
        endcase
      end
    end
  endtask

  task automatic drive_curr();
    for (int c = 0; c < NUM_CH; c++) begin
      curr_addr[c*CNT_W +: CNT_W] = 24'(m_curr_addr[c]);
      curr_wc[c*CNT_W +: CNT_W]   = 24'(m_curr_wc[c]);
    end
    dreq_st = 4'(m_dreq);
  endtask

  task automatic check_state(input string tag);
    logic [127:0] e_ba, e_bw, e_md;
    e_ba = '0; e_bw = '0; e_md = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      e_ba[c*CNT_W +: CNT_W] = 24'(m_base_addr[c]);
      e_bw[c*CNT_W +: CNT_W] = 24'(m_base_wc[c]);
      e_md[c*6 +: 6]         = 6'(m_mode[c]);
    end
    check({tag, " base_addr"}, 128'(base_addr), e_ba);
    check({tag, " base_wc"}, 128'(base_wc), e_bw);
    check({tag, " mode"}, 128'(mode), e_md);
    check({tag, " cmd"}, 128'(cmd), 128'(8'(m_cmd)));
    check({tag, " mask"}, 128'(mask), 128'(4'(m_mask)));
    check({tag, " sw_req"}, 128'(sw_req), 128'(4'(m_sw)));
    check({tag, " db_out"}, 128'(db_out), 128'(8'(exp_db)));
    check({tag, " idle db_oe"}, 128'(db_oe), 128'(0));
    check({tag, " idle pulses"}, 128'({load_addr, load_wc, mclr}), 128'(0));
  endtask

  task automatic do_op(input bit wr, input int unsigned a, input int unsigned d, input int hold,
                       input int unsigned tcv, input bit hl, input string tag);
    int unsigned rd_val, ld_a, ld_w;
    bit mc;
    @(negedge clk);
    cs_n = 1'b0; hlda = hl; addr_l = 4'(a); db_in = 8'(d); tc = 4'(tcv);
    if (wr) iow_n = 1'b0; else ior_n = 1'b0;
    @(negedge clk);
    tc = '0;
    rd_val = 0; ld_a = 0; ld_w = 0; mc = 0;
    if (!hl) model_event(wr, a, d, rd_val, ld_a, ld_w, mc);
    apply_tc(tcv);
    if (!hl && !wr) exp_db = rd_val;
    check({tag, " db_out"}, 128'(db_out), 128'(8'(exp_db)));
    check({tag, " db_oe"}, 128'(db_oe), 128'(!hl && !wr));
    check({tag, " load_addr"}, 128'(load_addr), 128'(4'(ld_a)));
    check({tag, " load_wc"}, 128'(load_wc), 128'(4'(ld_w)));
    check({tag, " mclr"}, 128'(mclr), 128'(mc));
    repeat (hold - 1) @(negedge clk);
    iow_n = 1'b1; ior_n = 1'b1; cs_n = 1'b1; hlda = 1'b0;
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic pulse_tc(input int unsigned v);
    @(negedge clk); tc = 4'(v);
    @(negedge clk); tc = '0;
    apply_tc(v);
  endtask

  typedef struct {
    bit          wr;
    int unsigned a;
    int unsigned d;
    bit          chk;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl[19];

  initial begin
    int base;
    tbl[0]  = '{1, 13, 0,    0, 8'h00};
    tbl[1]  = '{1, 11, 8'h04, 0, 8'h00};
    tbl[2]  = '{1, 11, 8'h49, 0, 8'h00};
    tbl[3]  = '{1, 11, 8'h8A, 0, 8'h00};
    tbl[4]  = '{1, 11, 8'hCB, 0, 8'h00};
    tbl[5]  = '{1, 14, 0,    0, 8'h00};
    tbl[6]  = '{0, 14, 0,    1, 8'h00};
    tbl[7]  = '{0, 11, 0,    1, 8'h04};
    tbl[8]  = '{0, 11, 0,    1, 8'h49};
    tbl[9]  = '{0, 11, 0,    1, 8'h8A};
    tbl[10] = '{0, 11, 0,    1, 8'hCB};
    tbl[11] = '{0, 11, 0,    1, 8'h04};
    tbl[12] = '{0, 15, 0,    1, 8'h00};
    tbl[13] = '{1, 10, 8'h05, 0, 8'h00};
    tbl[14] = '{0, 15, 0,    1, SB ? 8'h02 : 8'h00};
    tbl[15] = '{1, 9,  8'h07, 0, 8'h00};
    tbl[16] = '{1, 13, 0,    0, 8'h00};
    tbl[17] = '{0, 15, 0,    1, 8'h0F};
    tbl[18] = '{0, 11, 0,    1, 8'h04};

    model_reset();
    for (int c = 0; c < NUM_CH; c++) begin m_curr_addr[c] = 0; m_curr_wc[c] = 0; end
    m_dreq = 0;
    drive_curr();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_state("reset");
    do_op(0, 15, 0, 1, 0, 0, "rd_mask_reset");
    check("rd_mask_reset value", 128'(db_out), 128'(8'h0F));

    // 24-bit base address assembled over three byte writes
    base = load1_cnt;
    do_op(1, 12, 0, 1, 0, 0, "clr_bp");
    do_op(1, 2, 8'h11, 1, 0, 0, "ba1_b0");
    do_op(1, 2, 8'h22, 1, 0, 0, "ba1_b1");
    do_op(1, 2, 8'h33, 1, 0, 0, "ba1_b2");
    check("base_addr1 value", 128'(base_addr[47:24]), 128'(24'h332211));
    check("load_addr1 count", 128'(load1_cnt - base), 128'(1));

    // Long strobe counts as one access
    do_op(1, 12, 0, 1, 0, 0, "clr_bp2");
    do_op(1, 0, 8'hAA, 5, 0, 0, "hold_wr");
    do_op(1, 0, 8'hBB, 1, 0, 0, "after_hold");
    check("hold bp step", 128'(base_addr[23:0]), 128'(24'h00BBAA));

    // TC flags: set, clear on read, set wins over clear
    m_dreq = 4'hA; drive_curr();
    pulse_tc(4);
    do_op(0, 8, 0, 1, 0, 0, "status1");
    check("status1 value", 128'(db_out), 128'(8'hA4));
    do_op(0, 8, 0, 1, 0, 0, "status2");
    check("status2 value", 128'(db_out), 128'(8'hA0));
    do_op(0, 8, 0, 1, 4, 0, "status_tc_same");
    check("status_tc_same value", 128'(db_out), 128'(8'hA0));
    do_op(0, 8, 0, 1, 0, 0, "status3");
    check("status3 set wins", 128'(db_out), 128'(8'hA4));

    for (int i = 0; i < 19; i++) begin
      do_op(tbl[i].wr, tbl[i].a, tbl[i].d, 1, 0, 0, $sformatf("tbl%0d", i));
      if (tbl[i].chk) check($sformatf("tbl%0d value", i), 128'(db_out), 128'(tbl[i].exp));
    end

    do_op(1, 9, 8'h07, 1, 0, 0, "swreq3");
    check("swreq3 value", 128'(sw_req), 128'(SB ? 4'h8 : 4'h0));
    pulse_tc(8);
    @(negedge clk);
    check("swreq3 tc clear", 128'(sw_req), 128'(4'h0));

    for (int n = 0; n < 300; n++) begin
      bit wr, hl;
      int unsigned a, tcv;
      for (int c = 0; c < NUM_CH; c++) begin
        m_curr_addr[c] = $urandom & 24'hFFFFFF;
        m_curr_wc[c]   = $urandom & 24'hFFFFFF;
      end
      m_dreq = $urandom_range(0, 15);
      drive_curr();
      if ($urandom_range(0, 7) == 0) pulse_tc($urandom_range(0, 15));
      wr  = 1'($urandom_range(0, 1));
      a   = $urandom_range(0, 15);
      hl  = ($urandom_range(0, 9) == 0);
      tcv = (!wr && $urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0;
      do_op(wr, a, $urandom_range(0, 255), $urandom_range(1, 3), tcv, hl, $sformatf("rnd%0d", n));
    end

    // Reset during an access; strobe still low at release must not act
    @(negedge clk);
    cs_n = 1'b0; addr_l = 4'd0; db_in = 8'h77; iow_n = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    iow_n = 1'b1; cs_n = 1'b1;
    @(negedge clk);
    check("rst_mid base_addr0", 128'(base_addr[23:0]), 128'(24'h0));
    check_state("rst_mid");
    do_op(1, 0, 8'h55, 1, 0, 0, "post_rst_wr");
    check("post_rst_wr value", 128'(base_addr[23:0]), 128'(24'h000055));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
